// File: rtl/mig_cmd_arbiter_if.sv
// mig_cmd_arbiter_if: requester push/status groups, MIG command port and control for mig_cmd_arbiter
// Ports: master = requester/MIG side (drives pushes, enable, prio1, mig_cmd_full);
// slave = arbiter side (drives queue status, overflow, MIG command fields, grant_src, busy).
interface mig_cmd_arbiter_if #(
  parameter int ADDR_WIDTH = 30
);
  logic                  enable;
  logic                  prio1;
  logic                  rq0_cmd_en;
  logic [2:0]            rq0_cmd_instr;
  logic [5:0]            rq0_cmd_bl;
  logic [ADDR_WIDTH-1:0] rq0_cmd_byte_addr;
  logic                  rq0_cmd_full;
  logic                  rq0_cmd_empty;
  logic                  rq0_ovf;
  logic                  rq1_cmd_en;
  logic [2:0]            rq1_cmd_instr;
  logic [5:0]            rq1_cmd_bl;
  logic [ADDR_WIDTH-1:0] rq1_cmd_byte_addr;
  logic                  rq1_cmd_full;
  logic                  rq1_cmd_empty;
  logic                  rq1_ovf;
  logic                  mig_cmd_en;
  logic [2:0]            mig_cmd_instr;
  logic [5:0]            mig_cmd_bl;
  logic [ADDR_WIDTH-1:0] mig_cmd_byte_addr;
  logic                  mig_cmd_full;
  logic                  grant_src;
  logic                  busy;
  modport master (
    output enable, prio1, mig_cmd_full,
    output rq0_cmd_en, rq0_cmd_instr, rq0_cmd_bl, rq0_cmd_byte_addr,
    output rq1_cmd_en, rq1_cmd_instr, rq1_cmd_bl, rq1_cmd_byte_addr,
    input  rq0_cmd_full, rq0_cmd_empty, rq0_ovf, rq1_cmd_full, rq1_cmd_empty, rq1_ovf,
    input  mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr, grant_src, busy
  );
  modport slave (
    input  enable, prio1, mig_cmd_full,
    input  rq0_cmd_en, rq0_cmd_instr, rq0_cmd_bl, rq0_cmd_byte_addr,
    input  rq1_cmd_en, rq1_cmd_instr, rq1_cmd_bl, rq1_cmd_byte_addr,
    output rq0_cmd_full, rq0_cmd_empty, rq0_ovf, rq1_cmd_full, rq1_cmd_empty, rq1_ovf,
    output mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr, grant_src, busy
  );
endinterface

// File: rtl/mig_cmd_arbiter.sv
// mig_cmd_arbiter: shares one MIG command port between a frame writer (rq0) and a frame reader (rq1)
// Ports: clk; resetb (async, active-low); bus (slave modport) carrying enable, prio1,
// per-requester push/full/empty/ovf, MIG command outputs with mig_cmd_full, grant_src and busy.
module mig_cmd_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int MAX_GRANTS = 4
) (
  input logic              clk,
  input logic              resetb,
  mig_cmd_arbiter_if.slave bus
);
  localparam int W = 9 + ADDR_WIDTH;
  localparam logic [3:0] MAXG = 4'(MAX_GRANTS);
  typedef enum logic {ARB, GAP} state_t;
  state_t state_q, state_d;
  logic [W-1:0] mem_q [2][2];
  logic [W-1:0] mem_d [2][2];
  logic [1:0] cnt_q [2];
  logic [1:0] cnt_d [2];
  logic [W-1:0] cmd [2];
  logic [1:0] rd_q, rd_d, ovf_q, ovf_d, en, ne, push, pop;
  logic [W-1:0] mig_q, mig_d;
  logic mig_en_q, mig_en_d, grant_q, grant_d, last_q, last_d, go, win;
  logic [3:0] streak_q, streak_d;
  assign en = {bus.rq1_cmd_en, bus.rq0_cmd_en};
  assign cmd[0] = {bus.rq0_cmd_instr, bus.rq0_cmd_bl, bus.rq0_cmd_byte_addr};
  assign cmd[1] = {bus.rq1_cmd_instr, bus.rq1_cmd_bl, bus.rq1_cmd_byte_addr};
  assign ne = {cnt_q[1] != 2'd0, cnt_q[0] != 2'd0};
  assign go = bus.enable && state_q == ARB && !bus.mig_cmd_full && |ne;
  // Under prio1 the reader wins until its streak reaches MAX_GRANTS, then the writer gets one slot.
  assign win = ne == 2'b10 ? 1'b1 : ne == 2'b01 ? 1'b0 : bus.prio1 ? streak_q != MAXG : !last_q;
  always_comb begin
    state_d = go ? GAP : ARB;
    mem_d = mem_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    ovf_d = ovf_q;
    mig_en_d = go;
    mig_d = go ? mem_q[win][rd_q[win]] : mig_q;
    grant_d = go ? win : grant_q;
    last_d = go ? win : last_q;
    streak_d = !bus.prio1 || (go && !win) ? 4'd0 :
               go && ne[0] && streak_q != MAXG ? streak_q + 4'd1 : streak_q;
    push = '0;
    pop = '0;
    for (int i = 0; i < 2; i++) begin
      push[i] = bus.enable && en[i] && cnt_q[i] != 2'd2 && cmd[i][W-1 -: 3] != 3'd5;
      pop[i] = go && win == 1'(i);
      if (push[i]) mem_d[i][rd_q[i] ^ cnt_q[i][0]] = cmd[i];
      cnt_d[i] = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      rd_d[i] = rd_q[i] ^ pop[i];
      // Fullness is judged before this cycle's pop, so a same-cycle pop does not rescue the push.
      ovf_d[i] = ovf_q[i] | (bus.enable && en[i] && cnt_q[i] == 2'd2 && cmd[i][W-1 -: 3] != 3'd5);
    end
    if (!bus.enable) begin
      cnt_d = '{default: 2'd0};
      rd_d = '0;
      ovf_d = '0;
      streak_d = '0;
      last_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ARB;
      mem_q <= '{default: '0};
      cnt_q <= '{default: 2'd0};
      rd_q <= '0;
      ovf_q <= '0;
      mig_en_q <= 1'b0;
      mig_q <= '0;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      streak_q <= '0;
    end else begin
      state_q <= state_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
      mig_en_q <= mig_en_d;
      mig_q <= mig_d;
      grant_q <= grant_d;
      last_q <= last_d;
      streak_q <= streak_d;
    end
  end
  assign bus.rq0_cmd_full = cnt_q[0] == 2'd2;
  assign bus.rq1_cmd_full = cnt_q[1] == 2'd2;
  assign bus.rq0_cmd_empty = !ne[0];
  assign bus.rq1_cmd_empty = !ne[1];
  assign bus.rq0_ovf = ovf_q[0];
  assign bus.rq1_ovf = ovf_q[1];
  assign bus.mig_cmd_en = mig_en_q;
  assign bus.mig_cmd_instr = mig_q[W-1 -: 3];
  assign bus.mig_cmd_bl = mig_q[ADDR_WIDTH +: 6];
  assign bus.mig_cmd_byte_addr = mig_q[ADDR_WIDTH-1:0];
  assign bus.grant_src = grant_q;
  assign bus.busy = |ne || mig_en_q;
endmodule

// File: tb/tb_mig_cmd_arbiter.sv
// tb_mig_cmd_arbiter: directed scenarios plus random traffic against a queue-level reference model
module tb_mig_cmd_arbiter;
  localparam int AW = 30;
  localparam int MAXG = 4;
  typedef struct packed {
    logic [2:0]    instr;
    logic [5:0]    bl;
    logic [AW-1:0] addr;
  } cmd_t;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;
  mig_cmd_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  mig_cmd_arbiter #(.ADDR_WIDTH(AW), .MAX_GRANTS(MAXG)) dut (.clk(clk), .resetb(resetb), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  cmd_t mq0[$];
  cmd_t mq1[$];
  bit m_ovf0, m_ovf1, m_en, m_grant, m_last;
  int m_streak;
  cmd_t m_mig;
  logic [AW-1:0] lg_addr[$];
  bit lg_src[$];
  int lg_cyc[$];
  bit exp_pr[6] = '{1, 1, 1, 1, 0, 1};
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_ovf0 = 0; m_ovf1 = 0; m_en = 0; m_grant = 0; m_last = 1; m_streak = 0;
    m_mig = '0;
  endtask
  task automatic model_update();
    int s0, s1;
    bit w;
    cmd_t c;
    s0 = mq0.size();
    s1 = mq1.size();
    if (!bus.enable) begin
      mq0.delete();
      mq1.delete();
      m_en = 0; m_streak = 0; m_last = 1; m_ovf0 = 0; m_ovf1 = 0;
      return;
    end
    if (!m_en && !bus.mig_cmd_full && (s0 > 0 || s1 > 0)) begin
      w = s0 == 0 ? 1'b1 : s1 == 0 ? 1'b0 : bus.prio1 ? (m_streak < MAXG) : !m_last;
      c = w ? mq1.pop_front() : mq0.pop_front();
      m_mig = c; m_en = 1; m_grant = w; m_last = w;
      if (!w) m_streak = 0;
      else if (bus.prio1 && s0 > 0 && m_streak < MAXG) m_streak++;
    end else m_en = 0;
    if (!bus.prio1) m_streak = 0;
    if (bus.rq0_cmd_en && bus.rq0_cmd_instr != 3'd5) begin
      if (s0 < 2) mq0.push_back({bus.rq0_cmd_instr, bus.rq0_cmd_bl, bus.rq0_cmd_byte_addr});
      else m_ovf0 = 1;
    end
    if (bus.rq1_cmd_en && bus.rq1_cmd_instr != 3'd5) begin
      if (s1 < 2) mq1.push_back({bus.rq1_cmd_instr, bus.rq1_cmd_bl, bus.rq1_cmd_byte_addr});
      else m_ovf1 = 1;
    end
  endtask
  task automatic check_all();
    chk("rq0_full", bus.rq0_cmd_full, mq0.size() == 2);
    chk("rq0_empty", bus.rq0_cmd_empty, mq0.size() == 0);
    chk("rq0_ovf", bus.rq0_ovf, m_ovf0);
    chk("rq1_full", bus.rq1_cmd_full, mq1.size() == 2);
    chk("rq1_empty", bus.rq1_cmd_empty, mq1.size() == 0);
    chk("rq1_ovf", bus.rq1_ovf, m_ovf1);
    chk("mig_en", bus.mig_cmd_en, m_en);
    chk("mig_instr", bus.mig_cmd_instr, m_mig.instr);
    chk("mig_bl", bus.mig_cmd_bl, m_mig.bl);
    chk("mig_addr", bus.mig_cmd_byte_addr, m_mig.addr);
    chk("grant_src", bus.grant_src, m_grant);
    chk("busy", bus.busy, mq0.size() > 0 || mq1.size() > 0 || m_en);
  endtask
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    if (bus.mig_cmd_en) begin
      lg_addr.push_back(bus.mig_cmd_byte_addr);
      lg_src.push_back(bus.grant_src);
      lg_cyc.push_back(cyc);
    end
    bus.rq0_cmd_en = 0;
    bus.rq1_cmd_en = 0;
  endtask
  task automatic push0(logic [2:0] i, logic [5:0] b, logic [AW-1:0] a);
    bus.rq0_cmd_en = 1; bus.rq0_cmd_instr = i; bus.rq0_cmd_bl = b; bus.rq0_cmd_byte_addr = a;
  endtask
  task automatic push1(logic [2:0] i, logic [5:0] b, logic [AW-1:0] a);
    bus.rq1_cmd_en = 1; bus.rq1_cmd_instr = i; bus.rq1_cmd_bl = b; bus.rq1_cmd_byte_addr = a;
  endtask
  task automatic flush();
    bus.enable = 0;
    step();
    bus.enable = 1;
  endtask
  task automatic clear_log();
    lg_addr.delete();
    lg_src.delete();
    lg_cyc.delete();
  endtask
  initial begin
    bus.enable = 1; bus.prio1 = 0; bus.mig_cmd_full = 0;
    bus.rq0_cmd_en = 0; bus.rq0_cmd_instr = 0; bus.rq0_cmd_bl = 0; bus.rq0_cmd_byte_addr = 0;
    bus.rq1_cmd_en = 0; bus.rq1_cmd_instr = 0; bus.rq1_cmd_bl = 0; bus.rq1_cmd_byte_addr = 0;
    model_reset();
    #1;
    check_all();
    chk("rst_empty0", bus.rq0_cmd_empty, 1);
    @(posedge clk);
    #1;
    resetb = 1;
    push0(3'd0, 6'd15, 'h40);
    step();
    chk("single_e0_en", bus.mig_cmd_en, 0);
    step();
    chk("single_en", bus.mig_cmd_en, 1);
    chk("single_instr", bus.mig_cmd_instr, 0);
    chk("single_bl", bus.mig_cmd_bl, 15);
    chk("single_addr", bus.mig_cmd_byte_addr, 'h40);
    chk("single_src", bus.grant_src, 0);
    chk("single_empty", bus.rq0_cmd_empty, 1);
    step();
    chk("single_en_off", bus.mig_cmd_en, 0);
    chk("single_busy_off", bus.busy, 0);
    flush();
    bus.mig_cmd_full = 1;
    push0(3'd0, 6'd3, 'h000); push1(3'd1, 6'd3, 'h1000);
    step();
    push0(3'd0, 6'd3, 'h040); push1(3'd1, 6'd3, 'h1040);
    step();
    clear_log();
    bus.mig_cmd_full = 0;
    repeat (8) step();
    chk("rr_count", lg_addr.size(), 4);
    if (lg_addr.size() == 4) begin
      chk("rr_a0", lg_addr[0], 'h000);
      chk("rr_a1", lg_addr[1], 'h1000);
      chk("rr_a2", lg_addr[2], 'h040);
      chk("rr_a3", lg_addr[3], 'h1040);
      for (int k = 0; k < 3; k++) chk("rr_gap", lg_cyc[k+1] - lg_cyc[k], 2);
    end
    flush();
    bus.mig_cmd_full = 1;
    push0(3'd0, 6'd1, 'h200); push1(3'd1, 6'd1, 'h3000);
    step();
    push1(3'd1, 6'd1, 'h3040);
    step();
    clear_log();
    bus.prio1 = 1;
    bus.mig_cmd_full = 0;
    for (int k = 0; k < 14; k++) begin
      if (!bus.rq1_cmd_full) push1(3'd1, 6'd1, AW'('h4000 + k * 'h40));
      step();
    end
    chk("prio_count", lg_src.size() >= 6, 1);
    if (lg_src.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("prio_src", lg_src[k], exp_pr[k]);
      chk("prio_rq0_addr", lg_addr[4], 'h200);
    end
    bus.prio1 = 0;
    flush();
    bus.mig_cmd_full = 1;
    push1(3'd1, 6'd7, 'h2A0);
    step();
    clear_log();
    repeat (9) step();
    chk("bp_no_pulse", lg_addr.size(), 0);
    bus.mig_cmd_full = 0;
    step();
    chk("bp_en", bus.mig_cmd_en, 1);
    chk("bp_addr", bus.mig_cmd_byte_addr, 'h2A0);
    chk("bp_bl", bus.mig_cmd_bl, 7);
    chk("bp_instr", bus.mig_cmd_instr, 1);
    step();
    flush();
    bus.mig_cmd_full = 1;
    push0(3'd5, 6'd0, 'h999);
    step();
    chk("idle_ignored", bus.rq0_cmd_empty, 1);
    push0(3'd0, 6'd2, 'h100); step();
    push0(3'd0, 6'd2, 'h140); step();
    push0(3'd0, 6'd2, 'h180); step();
    chk("ovf_flag", bus.rq0_ovf, 1);
    chk("ovf_full", bus.rq0_cmd_full, 1);
    clear_log();
    bus.mig_cmd_full = 0;
    repeat (8) step();
    chk("ovf_count", lg_addr.size(), 2);
    if (lg_addr.size() == 2) begin
      chk("ovf_a0", lg_addr[0], 'h100);
      chk("ovf_a1", lg_addr[1], 'h140);
    end
    bus.mig_cmd_full = 1;
    push0(3'd0, 6'd0, 'h500); push1(3'd1, 6'd0, 'h600); step();
    push0(3'd0, 6'd0, 'h540); push1(3'd1, 6'd0, 'h640); step();
    bus.mig_cmd_full = 0;
    push0(3'd0, 6'd0, 'h580); push1(3'd1, 6'd0, 'h680);
    step();
    chk("fl_gap_en", bus.mig_cmd_en, 1);
    chk("fl_ovf0", bus.rq0_ovf, 1);
    chk("fl_ovf1", bus.rq1_ovf, 1);
    flush();
    chk("fl_empty0", bus.rq0_cmd_empty, 1);
    chk("fl_empty1", bus.rq1_cmd_empty, 1);
    chk("fl_en", bus.mig_cmd_en, 0);
    chk("fl_ovf0_clr", bus.rq0_ovf, 0);
    chk("fl_ovf1_clr", bus.rq1_ovf, 0);
    clear_log();
    repeat (5) step();
    chk("fl_quiet", lg_addr.size(), 0);
    push0(3'd2, 6'd4, 'h50);
    step();
    step();
    chk("ar_pulse", bus.mig_cmd_en, 1);
    #2;
    resetb = 0;
    #1;
    model_reset();
    chk("ar_en_drop", bus.mig_cmd_en, 0);
    check_all();
    @(posedge clk);
    #1;
    resetb = 1;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 1) == 1) push0(3'($urandom_range(0, 7)), 6'($urandom), AW'($urandom));
      if ($urandom_range(0, 1) == 1) push1(3'($urandom_range(0, 7)), 6'($urandom), AW'($urandom));
      bus.mig_cmd_full = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 19) == 0) bus.prio1 = !bus.prio1;
      bus.enable = $urandom_range(0, 49) != 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
